// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_ctrl_pkg                                                  |
// | Brief    : Shared encodings for the accumulator CPU control sequencer.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_F1   = 4'd0,
        S_F2   = 4'd1,
        S_F3   = 4'd2,
        S_F4   = 4'd3,
        S_DEC  = 4'd4,
        S_EX1  = 4'd5,
        S_EX2  = 4'd6,
        S_EX3  = 4'd7,
        S_EX4  = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // Opcode class field, opcode[5:4]
    localparam logic [1:0] c_cls_misc = 2'b00;
    localparam logic [1:0] c_cls_mvac = 2'b01;
    localparam logic [1:0] c_cls_mvr  = 2'b10;
    localparam logic [1:0] c_cls_alu  = 2'b11;

    localparam logic [5:0] c_op_nop    = 6'h00;
    localparam logic [5:0] c_op_halt   = 6'h01;
    localparam logic [5:0] c_op_ldac   = 6'h02;
    localparam logic [5:0] c_op_stac   = 6'h03;
    localparam logic [5:0] c_op_jmpnz  = 6'h04;
    localparam logic [5:0] c_op_inc_ac = 6'h08;
    localparam logic [5:0] c_op_inc_ra = 6'h09;
    localparam logic [5:0] c_op_inc_rb = 6'h0A;
    localparam logic [5:0] c_op_inc_rc = 6'h0B;

    // Decoded instruction kind
    localparam logic [3:0] c_k_nop   = 4'd0;
    localparam logic [3:0] c_k_halt  = 4'd1;
    localparam logic [3:0] c_k_ldac  = 4'd2;
    localparam logic [3:0] c_k_stac  = 4'd3;
    localparam logic [3:0] c_k_jmpnz = 4'd4;
    localparam logic [3:0] c_k_inc   = 4'd5;
    localparam logic [3:0] c_k_mvac  = 4'd6;
    localparam logic [3:0] c_k_mvr   = 4'd7;
    localparam logic [3:0] c_k_alu   = 4'd8;

    localparam logic [3:0] c_reg_max = 4'd8;

    localparam logic [3:0] c_mux_dr = 4'd0;
    localparam logic [3:0] c_mux_r1 = 4'd1;
    localparam logic [3:0] c_mux_r2 = 4'd2;
    localparam logic [3:0] c_mux_r3 = 4'd3;
    localparam logic [3:0] c_mux_ra = 4'd4;
    localparam logic [3:0] c_mux_rb = 4'd5;
    localparam logic [3:0] c_mux_rc = 4'd6;
    localparam logic [3:0] c_mux_ac = 4'd7;
    localparam logic [3:0] c_mux_pc = 4'd8;

    localparam int c_cb_pc = 9;
    localparam int c_cb_ra = 8;
    localparam int c_cb_rb = 7;
    localparam int c_cb_rc = 6;
    localparam int c_cb_r1 = 5;
    localparam int c_cb_r2 = 4;
    localparam int c_cb_r3 = 3;
    localparam int c_cb_dr = 2;
    localparam int c_cb_ar = 1;
    localparam int c_cb_ac = 0;

    localparam logic [2:0] c_alu_pass = 3'd0;
    localparam logic [2:0] c_alu_add  = 3'd1;
    localparam logic [2:0] c_alu_sub  = 3'd2;
    localparam logic [2:0] c_alu_mul  = 3'd3;
    localparam logic [2:0] c_alu_and  = 3'd4;

    // Register index (same numbering as mux_sel) to its C-bus write enable
    function automatic logic [9:0] reg_wr_en(input logic [3:0] idx);
        logic [9:0] v;
        v = '0;
        case (idx)
            c_mux_dr: v[c_cb_dr] = 1'b1;
            c_mux_r1: v[c_cb_r1] = 1'b1;
            c_mux_r2: v[c_cb_r2] = 1'b1;
            c_mux_r3: v[c_cb_r3] = 1'b1;
            c_mux_ra: v[c_cb_ra] = 1'b1;
            c_mux_rb: v[c_cb_rb] = 1'b1;
            c_mux_rc: v[c_cb_rc] = 1'b1;
            c_mux_ac: v[c_cb_ac] = 1'b1;
            c_mux_pc: v[c_cb_pc] = 1'b1;
            default:  v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] alu_src_mux(input logic [1:0] src);
        case (src)
            2'd0:    return c_mux_r1;
            2'd1:    return c_mux_r2;
            2'd2:    return c_mux_r3;
            default: return c_mux_dr;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ctrl_decode                                                   |
// | Brief    : Combinational opcode decode: kind, register/mux, ALU op, legal|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] kind,
    output logic [3:0] reg_idx,
    output logic [1:0] inc_sel,
    output logic [2:0] alu_op,
    output logic       legal
);

    always_comb begin
        kind    = c_k_nop;
        reg_idx = opcode[3:0];
        inc_sel = opcode[1:0];
        alu_op  = c_alu_pass;
        legal   = 1'b0;
        case (opcode[5:4])
            c_cls_misc: begin
                case (opcode)
                    c_op_nop:   begin kind = c_k_nop;   legal = 1'b1; end
                    c_op_halt:  begin kind = c_k_halt;  legal = 1'b1; end
                    c_op_ldac:  begin kind = c_k_ldac;  legal = 1'b1; end
                    c_op_stac:  begin kind = c_k_stac;  legal = 1'b1; end
                    c_op_jmpnz: begin kind = c_k_jmpnz; legal = 1'b1; end
                    c_op_inc_ac, c_op_inc_ra, c_op_inc_rb, c_op_inc_rc: begin
                        kind  = c_k_inc;
                        legal = 1'b1;
                    end
                    default:    legal = 1'b0;
                endcase
            end
            c_cls_mvac: begin
                kind  = c_k_mvac;
                legal = (opcode[3:0] <= c_reg_max);
            end
            c_cls_mvr: begin
                kind  = c_k_mvr;
                legal = (opcode[3:0] <= c_reg_max);
            end
            default: begin
                // ALU ops map 0..3 onto ADD..AND; source field selects R1/R2/R3/DR
                kind    = c_k_alu;
                reg_idx = alu_src_mux(opcode[1:0]);
                alu_op  = {1'b0, opcode[3:2]} + 3'd1;
                legal   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_sequencer                                             |
// | Brief    : Fetch-decode-execute Moore controller for the 16-bit acc CPU. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       z_flag,
    output logic       ld_ir,
    output logic       pc_inc,
    output logic       ac_inc,
    output logic       ra_inc,
    output logic       rb_inc,
    output logic       rc_inc,
    output logic [9:0] c_bus_ctrl,
    output logic [3:0] mux_sel,
    output logic       dr_read,
    output logic       mem_write,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       illegal
);

    state_t     r_state;
    logic [5:0] r_opcode;
    logic       r_illegal;

    logic [5:0] w_dec_opcode;
    logic [3:0] w_kind;
    logic [3:0] w_reg_idx;
    logic [1:0] w_inc_sel;
    logic [2:0] w_alu_op;
    logic       w_legal;

    // DEC branches on the live IR output; execute states use the latched copy
    assign w_dec_opcode = (r_state == S_DEC) ? opcode : r_opcode;

    ctrl_decode u_decode (
        .opcode  (w_dec_opcode),
        .kind    (w_kind),
        .reg_idx (w_reg_idx),
        .inc_sel (w_inc_sel),
        .alu_op  (w_alu_op),
        .legal   (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_F1;
            r_opcode  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_F1:  r_state <= S_F2;
                S_F2:  r_state <= S_F3;
                S_F3:  r_state <= S_F4;
                S_F4:  r_state <= S_DEC;
                S_DEC: begin
                    r_opcode <= opcode;
                    if (!w_legal) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else if (w_kind == c_k_halt) begin
                        r_state <= S_HALT;
                    end else if (w_kind == c_k_nop) begin
                        r_state <= S_F1;
                    end else begin
                        r_state <= S_EX1;
                    end
                end
                S_EX1:   r_state <= (w_kind == c_k_ldac || w_kind == c_k_stac) ? S_EX2 : S_F1;
                S_EX2:   r_state <= S_EX3;
                S_EX3:   r_state <= (w_kind == c_k_ldac) ? S_EX4 : S_F1;
                S_EX4:   r_state <= S_F1;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    // rst masks every output, so the cycle in which reset is sampled issues nothing
    always_comb begin
        ld_ir      = 1'b0;
        pc_inc     = 1'b0;
        ac_inc     = 1'b0;
        ra_inc     = 1'b0;
        rb_inc     = 1'b0;
        rc_inc     = 1'b0;
        c_bus_ctrl = '0;
        mux_sel    = c_mux_dr;
        dr_read    = 1'b0;
        mem_write  = 1'b0;
        alu_op     = c_alu_pass;
        halted     = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            illegal = r_illegal;
            case (r_state)
                S_F1: begin
                    mux_sel            = c_mux_pc;
                    c_bus_ctrl[c_cb_ar] = 1'b1;
                end
                S_F3: dr_read = 1'b1;
                S_F4: begin
                    ld_ir  = 1'b1;
                    pc_inc = 1'b1;
                end
                S_EX1: begin
                    case (w_kind)
                        c_k_mvac: begin
                            mux_sel             = w_reg_idx;
                            c_bus_ctrl[c_cb_ac] = 1'b1;
                        end
                        c_k_mvr: begin
                            mux_sel    = c_mux_ac;
                            c_bus_ctrl = reg_wr_en(w_reg_idx);
                        end
                        c_k_alu: begin
                            mux_sel             = w_reg_idx;
                            alu_op              = w_alu_op;
                            c_bus_ctrl[c_cb_ac] = 1'b1;
                        end
                        c_k_inc: begin
                            case (w_inc_sel)
                                2'd0:    ac_inc = 1'b1;
                                2'd1:    ra_inc = 1'b1;
                                2'd2:    rb_inc = 1'b1;
                                default: rc_inc = 1'b1;
                            endcase
                        end
                        c_k_jmpnz: begin
                            mux_sel             = c_mux_r1;
                            c_bus_ctrl[c_cb_pc] = !z_flag;
                        end
                        c_k_ldac, c_k_stac: begin
                            mux_sel             = c_mux_ra;
                            c_bus_ctrl[c_cb_ar] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EX2: begin
                    if (w_kind == c_k_stac) begin
                        mux_sel             = c_mux_ac;
                        c_bus_ctrl[c_cb_dr] = 1'b1;
                    end
                end
                S_EX3: begin
                    dr_read   = (w_kind == c_k_ldac);
                    mem_write = (w_kind == c_k_stac);
                end
                S_EX4: begin
                    mux_sel             = c_mux_dr;
                    c_bus_ctrl[c_cb_ac] = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_control_sequencer                                          |
// | Brief    : Self-checking bench: datapath model, per-instruction control  |
// |            word model and directed scenarios for control_sequencer.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode;
    logic       z_flag;
    logic       ld_ir, pc_inc, ac_inc, ra_inc, rb_inc, rc_inc;
    logic [9:0] c_bus_ctrl;
    logic [3:0] mux_sel;
    logic       dr_read, mem_write;
    logic [2:0] alu_op;
    logic       halted, illegal;

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .z_flag     (z_flag),
        .ld_ir      (ld_ir),
        .pc_inc     (pc_inc),
        .ac_inc     (ac_inc),
        .ra_inc     (ra_inc),
        .rb_inc     (rb_inc),
        .rc_inc     (rc_inc),
        .c_bus_ctrl (c_bus_ctrl),
        .mux_sel    (mux_sel),
        .dr_read    (dr_read),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld_ir, pc_inc, ac_inc, ra_inc, rb_inc, rc_inc;
        logic [9:0] cbus;
        logic [3:0] mux;
        logic       dr_read, mem_write;
        logic [2:0] alu;
        logic       halted, illegal;
    } ctl_t;

    ctl_t act;
    assign act = {ld_ir, pc_inc, ac_inc, ra_inc, rb_inc, rc_inc, c_bus_ctrl, mux_sel,
                  dr_read, mem_write, alu_op, halted, illegal};

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Register unit + RAM model driven by the controller's strobes
    logic [15:0] pc, ra, rb, rc, r1, r2, r3, dr, ar, ac, ir;
    logic [15:0] mem  [256];
    logic [15:0] prog [256];
    logic [15:0] init_pc, init_ra, init_r1, init_r2, init_ac;
    logic        tb_init = 1'b1;
    int          n_memw;
    logic [15:0] bbus, cval;

    assign opcode = ir[5:0];
    assign z_flag = (ac == 16'h0000);

    always_comb begin
        case (mux_sel)
            4'd0:    bbus = dr;
            4'd1:    bbus = r1;
            4'd2:    bbus = r2;
            4'd3:    bbus = r3;
            4'd4:    bbus = ra;
            4'd5:    bbus = rb;
            4'd6:    bbus = rc;
            4'd7:    bbus = ac;
            4'd8:    bbus = pc;
            default: bbus = 16'hDEAD;
        endcase
        case (alu_op)
            3'd0:    cval = bbus;
            3'd1:    cval = ac + bbus;
            3'd2:    cval = ac - bbus;
            3'd3:    cval = ac * bbus;
            3'd4:    cval = ac & bbus;
            default: cval = 16'hBAD0;
        endcase
    end

    always @(posedge clk) begin
        if (tb_init) begin
            pc <= init_pc; ra <= init_ra; rb <= 16'h0; rc <= 16'h0;
            r1 <= init_r1; r2 <= init_r2; r3 <= 16'h0;
            dr <= 16'h0; ar <= 16'h0; ac <= init_ac; ir <= 16'h0;
            n_memw <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else begin
            if (c_bus_ctrl[9]) pc <= cval; else if (pc_inc) pc <= pc + 16'd1;
            if (c_bus_ctrl[8]) ra <= cval; else if (ra_inc) ra <= ra + 16'd1;
            if (c_bus_ctrl[7]) rb <= cval; else if (rb_inc) rb <= rb + 16'd1;
            if (c_bus_ctrl[6]) rc <= cval; else if (rc_inc) rc <= rc + 16'd1;
            if (c_bus_ctrl[5]) r1 <= cval;
            if (c_bus_ctrl[4]) r2 <= cval;
            if (c_bus_ctrl[3]) r3 <= cval;
            if (c_bus_ctrl[2]) dr <= cval; else if (dr_read) dr <= mem[ar[7:0]];
            if (c_bus_ctrl[1]) ar <= cval;
            if (c_bus_ctrl[0]) ac <= cval; else if (ac_inc) ac <= ac + 16'd1;
            if (ld_ir) ir <= dr;
            if (mem_write) begin
                mem[ar[7:0]] <= dr;
                n_memw <= n_memw + 1;
            end
        end
    end

    // Expected control words, one list per instruction, built from the instruction table
    ctl_t exp_q[$];
    logic halt_exp = 1'b0;
    logic ill_exp  = 1'b0;

    function automatic int wr_bit(input logic [3:0] idx);
        case (idx)
            4'd0: return 2;  4'd1: return 5;  4'd2: return 4;
            4'd3: return 3;  4'd4: return 8;  4'd5: return 7;
            4'd6: return 6;  4'd7: return 0;  default: return 9;
        endcase
    endfunction

    function automatic logic [3:0] src_mux(input logic [1:0] s);
        case (s)
            2'd0: return 4'd1; 2'd1: return 4'd2; 2'd2: return 4'd3; default: return 4'd0;
        endcase
    endfunction

    task automatic push_instr(input logic [5:0] op, input logic z);
        ctl_t w;
        w = '0; w.cbus[1] = 1'b1; w.mux = 4'd8; exp_q.push_back(w);
        w = '0; exp_q.push_back(w);
        w = '0; w.dr_read = 1'b1; exp_q.push_back(w);
        w = '0; w.ld_ir = 1'b1; w.pc_inc = 1'b1; exp_q.push_back(w);
        w = '0; exp_q.push_back(w);
        w = '0;
        if (op == 6'h00) begin
        end else if (op == 6'h01) begin
            halt_exp = 1'b1;
        end else if (op == 6'h02) begin
            w.mux = 4'd4; w.cbus[1] = 1'b1; exp_q.push_back(w);
            w = '0; exp_q.push_back(w);
            w = '0; w.dr_read = 1'b1; exp_q.push_back(w);
            w = '0; w.mux = 4'd0; w.cbus[0] = 1'b1; exp_q.push_back(w);
        end else if (op == 6'h03) begin
            w.mux = 4'd4; w.cbus[1] = 1'b1; exp_q.push_back(w);
            w = '0; w.mux = 4'd7; w.cbus[2] = 1'b1; exp_q.push_back(w);
            w = '0; w.mem_write = 1'b1; exp_q.push_back(w);
        end else if (op == 6'h04) begin
            w.mux = 4'd1; w.cbus[9] = !z; exp_q.push_back(w);
        end else if (op >= 6'h08 && op <= 6'h0B) begin
            w.ac_inc = (op == 6'h08); w.ra_inc = (op == 6'h09);
            w.rb_inc = (op == 6'h0A); w.rc_inc = (op == 6'h0B);
            exp_q.push_back(w);
        end else if ((op[5:4] == 2'b01 || op[5:4] == 2'b10) && op[3:0] > 4'd8) begin
            halt_exp = 1'b1; ill_exp = 1'b1;
        end else if (op[5:4] == 2'b01) begin
            w.mux = op[3:0]; w.cbus[0] = 1'b1; exp_q.push_back(w);
        end else if (op[5:4] == 2'b10) begin
            w.mux = 4'd7; w.cbus[wr_bit(op[3:0])] = 1'b1; exp_q.push_back(w);
        end else if (op[5:4] == 2'b11) begin
            w.mux = src_mux(op[1:0]); w.alu = {1'b0, op[3:2]} + 3'd1; w.cbus[0] = 1'b1;
            exp_q.push_back(w);
        end else begin
            halt_exp = 1'b1; ill_exp = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        ctl_t e;
        if (rst) begin
            exp_q.delete();
            halt_exp = 1'b0;
            ill_exp  = 1'b0;
            e = '0;
        end else begin
            if (exp_q.size() == 0 && !halt_exp) push_instr(mem[pc[7:0]][5:0], ac == 16'h0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '0; e.halted = 1'b1; e.illegal = ill_exp;
            end
        end
        n_cmp++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL ctl_word cycle %0d: got %h want %h", cyc_n, act, e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc_n);
        end
    endtask

    task automatic clear();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0;
        init_pc = 16'h0; init_ra = 16'h0; init_r1 = 16'h0; init_r2 = 16'h0; init_ac = 16'h0;
    endtask

    // 3 reset cycles; the datapath model reloads while reset is held
    task automatic start();
        @(posedge clk); #1; rst = 1'b1; tb_init = 1'b1;
        @(negedge clk);
        chk("rst_outputs_zero", 32'(act), 32'd0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; tb_init = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end (cycle %0d)", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int ndr;
        // MVAC R2
        clear(); prog[8'h10] = 16'h0012; init_pc = 16'h0010; init_r2 = 16'h0055;
        start();
        cyc(1); chk("f1_cbus", 32'(c_bus_ctrl), 32'h002); chk("f1_mux", 32'(mux_sel), 32'd8);
        cyc(3); chk("ld_ir_c4", 32'(ld_ir), 32'd1);
        cyc(2); chk("mvac_cbus_c6", 32'(c_bus_ctrl), 32'h001); chk("mvac_mux_c6", 32'(mux_sel), 32'd2);
        cyc(1); chk("f1_cbus_c7", 32'(c_bus_ctrl), 32'h002); chk("mvac_ac", 32'(ac), 32'h0055);

        // LDAC
        clear(); prog[8'h10] = 16'h0002; prog[8'h40] = 16'h1234;
        init_pc = 16'h0010; init_ra = 16'h0040;
        start();
        ndr = 0;
        for (int i = 0; i < 9; i++) begin cyc(1); ndr += int'(dr_read); end
        chk("ldac_dr_reads", 32'(ndr), 32'd2);
        cyc(1); chk("ldac_ac", 32'(ac), 32'h1234); chk("ldac_next_f1", 32'(c_bus_ctrl), 32'h002);

        // JMPNZ taken and not taken
        clear(); prog[8'h20] = 16'h0004; init_pc = 16'h0020; init_r1 = 16'h0100; init_ac = 16'h0005;
        start(); cyc(7); chk("jmpnz_taken_pc", 32'(pc), 32'h0100);
        init_ac = 16'h0000;
        start(); cyc(7); chk("jmpnz_not_taken_pc", 32'(pc), 32'h0021);

        // Undefined opcode 0x1F
        clear(); prog[0] = 16'h001F;
        start(); cyc(5);
        for (int i = 0; i < 20; i++) begin
            cyc(1); chk("halt_illegal_hold", 32'({halted, illegal}), 32'd3);
        end
        start(); cyc(1);
        chk("halt_cleared_by_rst", 32'({halted, illegal}), 32'd0);
        chk("f1_after_halt_rst", 32'(c_bus_ctrl), 32'h002);

        // STAC interrupted by reset in EX2
        clear(); prog[8'h30] = 16'h0003; prog[8'h50] = 16'hAAAA;
        init_pc = 16'h0030; init_ra = 16'h0050; init_ac = 16'h7777;
        start(); cyc(6);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("stac_rst_no_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        cyc(1); chk("stac_rst_f1_cbus", 32'(c_bus_ctrl), 32'h002); chk("stac_rst_f1_mux", 32'(mux_sel), 32'd8);
        cyc(10); chk("stac_rst_memw_count", 32'(n_memw), 32'd0);
        chk("stac_rst_mem", 32'(mem[8'h50]), 32'hAAAA);

        // STAC to completion
        start(); cyc(9);
        chk("stac_mem", 32'(mem[8'h50]), 32'h7777); chk("stac_memw_count", 32'(n_memw), 32'd1);

        // INC AC wrap, ADD, MVR RB, INC RB, MUL, MVR PC jump, HALT
        clear();
        prog[0] = 16'h0008; prog[1] = 16'h0030; prog[2] = 16'h0025;
        prog[3] = 16'h000A; prog[4] = 16'h0038; prog[5] = 16'h0028; prog[9] = 16'h0001;
        init_ac = 16'hFFFF; init_r1 = 16'h0003;
        start(); cyc(44);
        chk("prog_ac", 32'(ac), 32'h0009); chk("prog_rb", 32'(rb), 32'h0004);
        chk("prog_pc", 32'(pc), 32'h000A); chk("prog_halt_legal", 32'({halted, illegal}), 32'd2);

        // MVR to register index 9 is illegal
        clear(); prog[0] = 16'h0029;
        start(); cyc(6); chk("mvr_idx9_illegal", 32'({halted, illegal}), 32'd3);

        // PC wrap through pc_inc
        clear(); init_pc = 16'hFFFF;
        start(); cyc(5); chk("pc_wrap", 32'(pc), 32'h0000);
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
